dds_wave_gen: RTL and testbench

- Parametrised multi-waveform DDS generator, the next generation of the basic fixed-step sawtooth/triangle/square generator.
- Adds a programmable frequency tuning word (FTW), phase offset, waveform select, pulse duty and amplitude scaling.
- Configuration is loaded through a valid/ready handshake and applied either immediately or glitch-free at the accumulator wrap.
- Output is one DAC sample per cycle and feeds a parallel R-2R/PWM DAC driver.

---
 rtl/dds_wave_gen.sv | 201 ++++++++++++++++++++
 tb/tb_dds_wave_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
// dds_wave_gen: multi-waveform DDS generator with a programmable FTW, phase offset,
// waveform select, pulse duty and amplitude scale.
// Latency: 3 cycles from the acc value and en to dac_out, out_valid and wrap_pulse.
// Backpressure: cfg_ready drops while a wrap-synchronous update is pending; the
// sample output has no backpressure.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   en                        advance the phase accumulator this cycle
//   cfg_valid / cfg_ready     config word handshake
//   cfg_ftw, cfg_poff         frequency tuning word, phase offset (ACC_W bits)
//   cfg_mode                  0 saw, 1 tri, 2 square, 3 pulse
//   cfg_duty                  pulse threshold (OUT_W bits)
//   cfg_amp                   amplitude scale; 2^AMP_W is unity gain, larger values clamp
//   cfg_sync                  1 = apply at the accumulator wrap, 0 = apply at once
//   dac_out                   DAC sample
//   out_valid                 sample came from an enabled accumulator step
//   wrap_pulse                sample is the first one after an accumulator wrap
// The parameters must satisfy OUT_W+1 <= ACC_W.
module dds_wave_gen #(
   parameter int ACC_W   = 16,
   parameter int OUT_W   = 10,
   parameter int AMP_W   = 8,
   parameter int FTW_RST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [ACC_W-1:0] cfg_ftw,
   input  logic [ACC_W-1:0] cfg_poff,
   input  logic [1:0]       cfg_mode,
   input  logic [OUT_W-1:0] cfg_duty,
   input  logic [AMP_W:0]   cfg_amp,
   input  logic             cfg_sync,
   output logic [OUT_W-1:0] dac_out,
   output logic             out_valid,
   output logic             wrap_pulse
);

   typedef enum logic [1:0] {
      MODE_SAW    = 2'd0,
      MODE_TRI    = 2'd1,
      MODE_SQUARE = 2'd2,
      MODE_PULSE  = 2'd3
   } wave_mode_t;

   localparam logic [ACC_W-1:0] FTW_INIT  = ACC_W'(FTW_RST);
   localparam logic [AMP_W:0]   AMP_UNITY = {1'b1, {AMP_W{1'b0}}};
   localparam logic [OUT_W-1:0] DUTY_INIT = {1'b1, {(OUT_W-1){1'b0}}};
   localparam int               PROD_W    = OUT_W + AMP_W + 1;

   // Active configuration
   logic [ACC_W-1:0] ftw, poff;
   wave_mode_t       mode;
   logic [OUT_W-1:0] duty;
   logic [AMP_W:0]   amp;

   // Shadow configuration, waiting for the wrap when pending is set
   logic [ACC_W-1:0] sh_ftw, sh_poff;
   wave_mode_t       sh_mode;
   logic [OUT_W-1:0] sh_duty;
   logic [AMP_W:0]   sh_amp;
   logic             pending;

   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   acc_sum;
   logic             wrap;
   logic             wrap_r;   // wrap flag belonging to the value now held in acc
   logic             accept;
   logic             copy;

   assign acc_sum   = {1'b0, acc} + {1'b0, ftw};
   assign wrap      = en & acc_sum[ACC_W];
   assign cfg_ready = ~pending;
   assign accept    = cfg_valid & ~pending;
   // A zero FTW or a stopped accumulator would never wrap, so the pending
   // word is applied on the next edge in those cases.
   assign copy      = pending & (wrap | ~en | (ftw == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         wrap_r <= 1'b0;
      end else begin
         if (en) acc <= acc_sum[ACC_W-1:0];
         wrap_r <= wrap;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ftw     <= FTW_INIT;
         poff    <= '0;
         mode    <= MODE_SAW;
         duty    <= DUTY_INIT;
         amp     <= AMP_UNITY;
         sh_ftw  <= FTW_INIT;
         sh_poff <= '0;
         sh_mode <= MODE_SAW;
         sh_duty <= DUTY_INIT;
         sh_amp  <= AMP_UNITY;
         pending <= 1'b0;
      end else if (accept) begin
         sh_ftw  <= cfg_ftw;
         sh_poff <= cfg_poff;
         sh_mode <= wave_mode_t'(cfg_mode);
         sh_duty <= cfg_duty;
         sh_amp  <= cfg_amp;
         if (cfg_sync) begin
            pending <= 1'b1;
         end else begin
            ftw  <= cfg_ftw;
            poff <= cfg_poff;
            mode <= wave_mode_t'(cfg_mode);
            duty <= cfg_duty;
            amp  <= cfg_amp;
         end
      end else if (copy) begin
         // On a wrap edge the add above still uses the old FTW; the new one
         // governs the following add.
         ftw     <= sh_ftw;
         poff    <= sh_poff;
         mode    <= sh_mode;
         duty    <= sh_duty;
         amp     <= sh_amp;
         pending <= 1'b0;
      end
   end

   // S1: phase with offset
   logic [ACC_W-1:0] ph;
   logic             v1, w1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph <= '0;
         v1 <= 1'b0;
         w1 <= 1'b0;
      end else begin
         ph <= acc + poff;
         v1 <= en;
         w1 <= wrap_r;
      end
   end

   // S2: waveform shaping from the top OUT_W+1 phase bits
   logic [OUT_W:0]   s;
   logic             s_msb;
   logic [OUT_W-1:0] s_lo, s_top, wave_nx, wave;
   logic             v2, w2;

   assign s     = ph[ACC_W-1 -: OUT_W+1];
   assign s_msb = s[OUT_W];
   assign s_lo  = s[OUT_W-1:0];
   assign s_top = s[OUT_W:1];

   always_comb begin
      wave_nx = s_top;
      case (mode)
         MODE_SAW:    wave_nx = s_top;
         MODE_TRI:    wave_nx = s_msb ? ~s_lo : s_lo;
         MODE_SQUARE: wave_nx = {OUT_W{s_msb}};
         MODE_PULSE:  wave_nx = (s_top < duty) ? {OUT_W{1'b1}} : '0;
         default:     wave_nx = s_top;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wave <= '0;
         v2   <= 1'b0;
         w2   <= 1'b0;
      end else begin
         wave <= wave_nx;
         v2   <= v1;
         w2   <= w1;
      end
   end

   // S3: amplitude scaling; clamping amp to unity keeps the product within OUT_W bits
   logic [AMP_W:0]    amp_c;
   logic [PROD_W-1:0] prod;

   assign amp_c = (amp > AMP_UNITY) ? AMP_UNITY : amp;
   assign prod  = {{(AMP_W+1){1'b0}}, wave} * {{OUT_W{1'b0}}, amp_c};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dac_out    <= '0;
         out_valid  <= 1'b0;
         wrap_pulse <= 1'b0;
      end else begin
         dac_out    <= prod[AMP_W +: OUT_W];
         out_valid  <= v2;
         wrap_pulse <= w2;
      end
   end

endmodule

// File: tb/tb_dds_wave_gen.sv
module tb_dds_wave_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] cfg_ftw;
   logic [15:0] cfg_poff;
   logic [1:0]  cfg_mode;
   logic [9:0]  cfg_duty;
   logic [8:0]  cfg_amp;
   logic        cfg_sync;
   logic [9:0]  dac_out;
   logic        out_valid;
   logic        wrap_pulse;

   dds_wave_gen #(.ACC_W(16), .OUT_W(10), .AMP_W(8), .FTW_RST(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ftw    (cfg_ftw),
      .cfg_poff   (cfg_poff),
      .cfg_mode   (cfg_mode),
      .cfg_duty   (cfg_duty),
      .cfg_amp    (cfg_amp),
      .cfg_sync   (cfg_sync),
      .dac_out    (dac_out),
      .out_valid  (out_valid),
      .wrap_pulse (wrap_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      int test;
      int idx;
      int dac;
      bit wrap;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   bit   mon_on = 1'b1;

   // Scoreboard monitor: every valid sample is matched against the queue head
   always @(negedge clk) begin
      if (mon_on && out_valid) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_sample got dac=%0d wrap=%0b required none", dac_out, wrap_pulse);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (dac_out !== e.dac[9:0] || wrap_pulse !== e.wrap) begin
               bad++;
               $display("FAIL test%0d_sample%0d got dac=%0d wrap=%0b required dac=%0d wrap=%0b",
                        e.test, e.idx, dac_out, wrap_pulse, e.dac, e.wrap);
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got %0d required %0d", name, got, want);
      end
   endtask

   // Hand-derived closed forms for each directed run starting from acc=0
   function automatic int exp_val(input int test, input int i);
      case (test)
         1:  return i % 1024;
         2:  return ((i % 2048) < 1024) ? (i % 2048) : 2047 - (i % 2048);
         3:  return ((i % 1024) >= 512) ? 511 : 0;
         4:  return ((i % 64) >= 32) ? 1023 : 0;
         5:  return ((i % 64) < 32) ? 1023 : 0;
         6:  return ((i % 1024) < 256) ? 1023 : 0;
         7:  return 0;
         8:  return (2 * i) % 1024;
         9:  return i / 64;
         10: return i % 1024;
         default: return -1;
      endcase
   endfunction

   task automatic push_exp(input int test, input int f, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.test = test;
         e.idx  = i;
         e.dac  = exp_val(test, i);
         e.wrap = (i > 0) && (((i * f) % 65536) == 0);
         q.push_back(e);
      end
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic load_cfg(input int f, input int po, input int md, input int dt,
                           input int am, input bit sy);
      bit ok;
      ok        = 1'b0;
      cfg_ftw   = 16'(f);
      cfg_poff  = 16'(po);
      cfg_mode  = 2'(md);
      cfg_duty  = 10'(dt);
      cfg_amp   = 9'(am);
      cfg_sync  = sy;
      cfg_valid = 1'b1;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = cfg_ready;
      end
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL cfg_accept got ready=0 required ready=1 within 20 cycles");
      end
   endtask

   task automatic run(input int n);
      en = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      en = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && q.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      chk("queue_drained", q.size(), 0);
      q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
      cfg_ftw = '0; cfg_poff = '0; cfg_mode = '0; cfg_duty = '0; cfg_amp = '0; cfg_sync = 1'b0;

      // Reset state
      #12;
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_dac_out", dac_out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_wrap_pulse", wrap_pulse, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // Saw, ftw=64: +1 per sample, wrap at 1024
      load_cfg(64, 0, 0, 512, 256, 0);
      push_exp(1, 64, 1030); run(1030); drain();

      // Triangle, ftw=32: period 2048
      do_reset(); load_cfg(32, 0, 1, 512, 256, 0);
      push_exp(2, 32, 2050); run(2050); drain();

      // Square at half amplitude
      do_reset(); load_cfg(64, 0, 2, 512, 128, 0);
      push_exp(3, 64, 1030); run(1030); drain();

      // Square with amp above unity clamps to full scale
      do_reset(); load_cfg(1024, 0, 2, 512, 300, 0);
      push_exp(4, 1024, 130); run(130); drain();

      // Square with half-cycle phase offset is inverted
      do_reset(); load_cfg(1024, 16'h8000, 2, 512, 256, 0);
      push_exp(5, 1024, 130); run(130); drain();

      // Pulse, duty=256
      do_reset(); load_cfg(64, 0, 3, 256, 256, 0);
      push_exp(6, 64, 1030); run(1030); drain();

      // Pulse, duty=0 is constant 0
      do_reset(); load_cfg(1024, 0, 3, 0, 256, 0);
      push_exp(7, 1024, 100); run(100); drain();

      // En low: dac_out holds, out_valid falls 3 cycles after en
      do_reset(); load_cfg(64, 0, 0, 512, 256, 0);
      push_exp(10, 64, 300); run(300);
      repeat (3) @(posedge clk);
      #1;
      chk("en_low_valid_drop", out_valid, 0);
      chk("en_low_dac_hold", dac_out, 300);
      repeat (10) @(posedge clk);
      #1;
      chk("en_low_dac_still", dac_out, 300);
      drain();

      // Sync update with en=0 applies on the next edge
      do_reset();
      cfg_ftw = 16'd128; cfg_poff = '0; cfg_mode = 2'd0; cfg_duty = 10'd512;
      cfg_amp = 9'd256; cfg_sync = 1'b1; cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      chk("sync_en0_pending", cfg_ready, 0);
      @(posedge clk);
      #1;
      chk("sync_en0_ready_back", cfg_ready, 1);
      push_exp(8, 128, 100); run(100); drain();

      // Sync update at acc=0x1000 while running ftw=64
      do_reset(); load_cfg(64, 0, 0, 512, 256, 0);
      for (int i = 0; i < 1624; i++) begin
         exp_t e;
         e.test = 11;
         e.idx  = i;
         e.dac  = (i < 1024) ? i : 2 * ((i - 1024) % 512);
         e.wrap = (i == 1024) || (i == 1536);
         q.push_back(e);
      end
      en = 1'b1;
      for (int k = 1; k <= 1624; k++) begin
         @(posedge clk);
         #1;
         if (k == 64) begin
            cfg_ftw = 16'd128; cfg_sync = 1'b1; cfg_mode = 2'd0; cfg_amp = 9'd256;
            cfg_valid = 1'b1;
         end
         if (k == 65) begin
            chk("sync_pending_ready", cfg_ready, 0);
            cfg_valid = 1'b0;
         end
         if (k == 100) begin
            cfg_ftw = 16'd256; cfg_sync = 1'b0; cfg_mode = 2'd1; cfg_valid = 1'b1;
         end
         if (k == 200) chk("sync_second_held_off", cfg_ready, 0);
         if (k == 300) cfg_valid = 1'b0;
         if (k == 1023) chk("sync_ready_before_wrap", cfg_ready, 0);
         if (k == 1024) chk("sync_ready_after_copy", cfg_ready, 1);
      end
      en = 1'b0;
      drain();

      // Reset while an update is pending
      do_reset(); load_cfg(64, 0, 0, 512, 256, 0);
      mon_on = 1'b0;
      en = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      cfg_ftw = 16'd128; cfg_sync = 1'b1; cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      chk("rstpend_pending", cfg_ready, 0);
      chk("rstpend_dac_before", (dac_out != 0) ? 1 : 0, 1);
      #2 rst = 1'b1;
      #1;
      chk("rstpend_cfg_ready", cfg_ready, 1);
      chk("rstpend_dac_out", dac_out, 0);
      chk("rstpend_out_valid", out_valid, 0);
      chk("rstpend_wrap_pulse", wrap_pulse, 0);
      en = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      mon_on = 1'b1;
      // FTW back at its reset value of 1
      push_exp(9, 1, 200); run(200); drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
